// File: rtl/svf_tdm.sv
// Time-multiplexed state-variable filter: NCH channels share one datapath, two clocks per channel.
// Latency: out_valid in cycle 2*NCH+1 after the sample_valid cycle; audio_out registered per channel.
// Backpressure: none; sample_valid while busy is dropped and counted in overrun_cnt (saturating).
module svf_tdm #(
    parameter int DW  = 8,
    parameter int NCH = 3,
    parameter int FW  = 11,
    parameter int QW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*DW-1:0] audio_in,
    input  logic              sample_valid,
    input  logic [NCH*FW-1:0] alpha1,
    input  logic [NCH*QW-1:0] alpha2,
    input  logic [NCH*2-1:0]  mode,
    output logic [NCH*DW-1:0] audio_out,
    output logic              out_valid,
    output logic              busy,
    output logic [7:0]        overrun_cnt
);
    // State width Q(DW).8; intermediate sums carry two guard bits before clamping.
    localparam int SW = DW + 8;
    localparam int EW = SW + 2;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, HB, L, DONE} state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CW-1:0]        ch;
    int                   chi;
    logic                 last_ch;

    // Frame snapshot so input/coefficient changes mid-frame have no effect.
    logic [NCH*DW-1:0]    in_f;
    logic [NCH*FW-1:0]    a1_f;
    logic [NCH*QW-1:0]    a2_f;
    logic [NCH*2-1:0]     mode_f;

    logic signed [SW-1:0] bp_q [NCH];
    logic signed [SW-1:0] lp_q [NCH];
    logic signed [SW-1:0] hp_q;
    logic signed [SW-1:0] bpn_q;

    logic signed [DW-1:0] in_ch;
    logic [FW-1:0]        a1_ch;
    logic [QW-1:0]        a2_ch;
    logic [1:0]           mode_ch;
    logic signed [SW-1:0] bp_cur;
    logic signed [SW-1:0] lp_cur;
    logic signed [SW-1:0] hp_c;
    logic signed [SW-1:0] bpn_c;
    logic signed [SW-1:0] lpn_c;
    logic signed [SW-1:0] notch_c;
    logic signed [SW-1:0] out_sel;

    function automatic logic signed [EW-1:0] sx(input logic signed [SW-1:0] v);
        return {{(EW-SW){v[SW-1]}}, v};
    endfunction

    // Clamp a guarded sum back into the SW-bit state range.
    function automatic logic signed [SW-1:0] sat(input logic signed [EW-1:0] v);
        logic signed [EW-1:0] hi;
        logic signed [EW-1:0] lo;
        hi = {{(EW-SW+1){1'b0}}, {(SW-1){1'b1}}};
        lo = {{(EW-SW+1){1'b1}}, {(SW-1){1'b0}}};
        if (v > hi)      return hi[SW-1:0];
        else if (v < lo) return lo[SW-1:0];
        else             return v[SW-1:0];
    endfunction

    // Full-precision product with an unsigned coefficient, floored by the arithmetic shift.
    function automatic logic signed [EW-1:0] f_mul(input logic signed [SW-1:0] v,
                                                   input logic [FW-1:0] a);
        logic signed [SW+FW:0] p;
        p = v * $signed({1'b0, a});
        p = p >>> (FW + 2);
        return p[EW-1:0];
    endfunction

    function automatic logic signed [EW-1:0] q_mul(input logic signed [SW-1:0] v,
                                                   input logic [QW-1:0] a);
        logic signed [SW+QW:0] p;
        p = v * $signed({1'b0, a});
        p = p >>> QW;
        return p[EW-1:0];
    endfunction

    assign chi     = int'(ch);
    assign last_ch = (ch == CW'(NCH - 1));

    // Shared datapath: HB terms from committed state, L terms from the stored bp_new.
    always_comb begin
        in_ch   = in_f[chi*DW +: DW];
        a1_ch   = a1_f[chi*FW +: FW];
        a2_ch   = a2_f[chi*QW +: QW];
        mode_ch = mode_f[chi*2 +: 2];
        bp_cur  = bp_q[ch];
        lp_cur  = lp_q[ch];
        hp_c    = sat(sx({in_ch, 8'd0}) - sx(lp_cur) - q_mul(bp_cur, a2_ch));
        bpn_c   = sat(sx(bp_cur) + f_mul(hp_c, a1_ch));
        lpn_c   = sat(sx(lp_cur) + f_mul(bpn_q, a1_ch));
        notch_c = sat(sx(hp_q) + sx(lpn_c));
        case (mode_ch)
            2'd0:    out_sel = lpn_c;
            2'd1:    out_sel = bpn_q;
            2'd2:    out_sel = hp_q;
            default: out_sel = notch_c;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: two steps per channel, then one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sample_valid) state_d = HB;
            HB:      state_d = L;
            L:       state_d = last_ch ? DONE : HB;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
    end

    // Frame capture, per-channel state update and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch        <= '0;
            in_f      <= '0;
            a1_f      <= '0;
            a2_f      <= '0;
            mode_f    <= '0;
            hp_q      <= '0;
            bpn_q     <= '0;
            audio_out <= '0;
            for (int k = 0; k < NCH; k++) begin
                bp_q[k] <= '0;
                lp_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (sample_valid) begin
                        in_f   <= audio_in;
                        a1_f   <= alpha1;
                        a2_f   <= alpha2;
                        mode_f <= mode;
                        ch     <= '0;
                    end
                end
                HB: begin
                    hp_q  <= hp_c;
                    bpn_q <= bpn_c;
                end
                L: begin
                    bp_q[ch] <= bpn_q;
                    lp_q[ch] <= lpn_c;
                    audio_out[chi*DW +: DW] <= out_sel[SW-1 -: DW];
                    if (!last_ch) ch <= ch + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Dropped-strobe counter, holds at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun_cnt <= '0;
        else if (sample_valid && busy && (overrun_cnt != 8'hFF))
            overrun_cnt <= overrun_cnt + 8'd1;
    end

endmodule

// File: tb/tb_svf_tdm.sv
// Directed bench for svf_tdm with default parameters (DW=8, NCH=3, FW=11, QW=2).
// Each task drives one scenario and compares against hand-computed values.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_svf_tdm;
    logic        clk;
    logic        rst_n;
    logic [23:0] audio_in;
    logic        sample_valid;
    logic [32:0] alpha1;
    logic [5:0]  alpha2;
    logic [5:0]  mode;
    logic [23:0] audio_out;
    logic        out_valid;
    logic        busy;
    logic [7:0]  overrun_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    svf_tdm dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .audio_in     (audio_in),
        .sample_valid (sample_valid),
        .alpha1       (alpha1),
        .alpha2       (alpha2),
        .mode         (mode),
        .audio_out    (audio_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun_cnt  (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic signed [7:0] out_ch(input int k);
        return audio_out[k*8 +: 8];
    endfunction

    task automatic set_ch(input int k, input logic signed [7:0] x, input logic [10:0] a1,
                          input logic [1:0] a2, input logic [1:0] m);
        audio_in[k*8 +: 8]  = x;
        alpha1[k*11 +: 11]  = a1;
        alpha2[k*2 +: 2]    = a2;
        mode[k*2 +: 2]      = m;
    endtask

    task automatic apply_reset;
        sample_valid = 1'b0;
        audio_in     = '0;
        alpha1       = '0;
        alpha2       = '0;
        mode         = '0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Strobe one frame; lat is the cycle (strobe cycle = 0) in which out_valid was seen.
    task automatic run_frame(output int lat);
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        sample_valid = 1'b0;
        audio_in = '0; alpha1 = '0; alpha2 = '0; mode = '0;
        rst_n = 1'b0;
        #2;
        n_checks++; if (audio_out !== 24'h0) $display("FAIL reset_audio_out got %h want 0", audio_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (overrun_cnt !== 8'd0) $display("FAIL reset_overrun got %0d want 0", overrun_cnt); else n_pass++;
    endtask

    task automatic test_dc_step;
        int lat;
        apply_reset();
        set_ch(0, 8'sd64, 11'd2047, 2'd2, 2'd0);
        set_ch(1, 8'sd64, 11'd2047, 2'd2, 2'd1);
        set_ch(2, 8'sd64, 11'd2047, 2'd2, 2'd2);
        run_frame(lat);
        n_checks++; if (lat != 7) $display("FAIL dc_latency got %0d want 7", lat); else n_pass++;
        n_checks++; if (out_ch(0) !== 8'sd3) $display("FAIL dc_lp got %0d want 3", out_ch(0)); else n_pass++;
        n_checks++; if (out_ch(1) !== 8'sd15) $display("FAIL dc_bp got %0d want 15", out_ch(1)); else n_pass++;
        n_checks++; if (out_ch(2) !== 8'sd64) $display("FAIL dc_hp got %0d want 64", out_ch(2)); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL dc_valid_pulse got %b want 0", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL dc_busy_idle got %b want 0", busy); else n_pass++;
        audio_in = 24'h7F7F7F;
        repeat (5) begin @(posedge clk); #1; end
        n_checks++; if (audio_out !== 24'h400F03) $display("FAIL dc_hold got %h want 400f03", audio_out); else n_pass++;
    endtask

    task automatic test_notch;
        int lat;
        apply_reset();
        set_ch(0, 8'sd64, 11'd2047, 2'd2, 2'd3);
        run_frame(lat);
        n_checks++; if (out_ch(0) !== 8'sd67) $display("FAIL notch got %0d want 67", out_ch(0)); else n_pass++;
    endtask

    task automatic test_dc_convergence;
        int lat;
        int late = 0;
        apply_reset();
        set_ch(0, 8'sd64, 11'd2047, 2'd2, 2'd0);
        set_ch(2, 8'sd64, 11'd2047, 2'd2, 2'd2);
        for (int i = 0; i < 200; i++) begin
            run_frame(lat);
            if (lat != 7) late++;
        end
        n_checks++; if (late != 0) $display("FAIL conv_frames late=%0d want 0", late); else n_pass++;
        n_checks++; if (out_ch(0) !== 8'sd63 && out_ch(0) !== 8'sd64)
            $display("FAIL conv_lp got %0d want 63 or 64", out_ch(0)); else n_pass++;
        n_checks++; if (out_ch(2) !== 8'sd0 && out_ch(2) !== -8'sd1)
            $display("FAIL conv_hp got %0d want 0 or -1", out_ch(2)); else n_pass++;
    endtask

    task automatic test_overrun;
        int pulses = 0;
        int vcyc   = -1;
        apply_reset();
        set_ch(0, 8'sd64, 11'd2047, 2'd2, 2'd0);
        sample_valid = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 15; c++) begin
            sample_valid = (c == 3 || c == 7);
            if (c == 3) set_ch(0, 8'sd127, 11'd100, 2'd0, 2'd1);
            if (out_valid === 1'b1) begin
                pulses++;
                vcyc = c;
            end
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;
        n_checks++; if (pulses != 1) $display("FAIL ovr_pulses got %0d want 1", pulses); else n_pass++;
        n_checks++; if (vcyc != 7) $display("FAIL ovr_valid_cycle got %0d want 7", vcyc); else n_pass++;
        n_checks++; if (overrun_cnt !== 8'd2) $display("FAIL ovr_count got %0d want 2", overrun_cnt); else n_pass++;
        n_checks++; if (out_ch(0) !== 8'sd3) $display("FAIL ovr_capture got %0d want 3", out_ch(0)); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL ovr_no_frame got %b want 0", busy); else n_pass++;
        sample_valid = 1'b1;
        repeat (400) begin @(posedge clk); #1; end
        sample_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        n_checks++; if (overrun_cnt !== 8'd255) $display("FAIL ovr_saturate got %0d want 255", overrun_cnt); else n_pass++;
    endtask

    task automatic test_saturation;
        int lat;
        int first_v = 0;
        int max_v = -1000;
        int min_v = 1000;
        int v;
        apply_reset();
        set_ch(0, 8'sd127, 11'd2047, 2'd0, 2'd1);
        for (int i = 0; i < 50; i++) begin
            run_frame(lat);
            v = int'(out_ch(0));
            if (i == 0) first_v = v;
            if (v > max_v) max_v = v;
            if (v < min_v) min_v = v;
        end
        n_checks++; if (first_v != 31) $display("FAIL sat_first got %0d want 31", first_v); else n_pass++;
        n_checks++; if (max_v != 127) $display("FAIL sat_peak got %0d want 127", max_v); else n_pass++;
        n_checks++; if (min_v < 0) $display("FAIL sat_sign got min %0d want >= 0", min_v); else n_pass++;
    endtask

    task automatic test_channel_independence;
        int lat;
        int ch2_bad = 0;
        apply_reset();
        set_ch(0, 8'sd64, 11'd2047, 2'd2, 2'd0);
        set_ch(1, 8'sh80, 11'd2047, 2'd2, 2'd0);
        set_ch(2, 8'sd0, 11'd2047, 2'd2, 2'd0);
        run_frame(lat);
        n_checks++; if (out_ch(1) !== 8'shF8) $display("FAIL ind_first_ch1 got %0d want -8", out_ch(1)); else n_pass++;
        n_checks++; if (out_ch(0) !== 8'sd3) $display("FAIL ind_first_ch0 got %0d want 3", out_ch(0)); else n_pass++;
        for (int i = 0; i < 150; i++) begin
            run_frame(lat);
            if (out_ch(2) !== 8'sd0) ch2_bad++;
        end
        n_checks++; if (ch2_bad != 0) $display("FAIL ind_ch2 nonzero frames=%0d want 0", ch2_bad); else n_pass++;
        n_checks++; if (out_ch(1) !== 8'sh80 && out_ch(1) !== 8'sh81)
            $display("FAIL ind_ch1 got %0d want -128 or -127", out_ch(1)); else n_pass++;
    endtask

    task automatic test_reset_midframe;
        int lat;
        int saw = 0;
        apply_reset();
        set_ch(0, 8'sd64, 11'd2047, 2'd2, 2'd0);
        run_frame(lat);
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        @(posedge clk); #1;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        n_checks++; if (overrun_cnt !== 8'd1) $display("FAIL mid_pre_overrun got %0d want 1", overrun_cnt); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (audio_out !== 24'h0) $display("FAIL mid_audio_out got %h want 0", audio_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (overrun_cnt !== 8'd0) $display("FAIL mid_overrun got %0d want 0", overrun_cnt); else n_pass++;
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b0) saw++;
        end
        n_checks++; if (saw != 0) $display("FAIL mid_no_pulse got %0d want 0", saw); else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(lat);
        n_checks++; if (lat != 7) $display("FAIL mid_restart_latency got %0d want 7", lat); else n_pass++;
        n_checks++; if (out_ch(0) !== 8'sd3) $display("FAIL mid_restart_lp got %0d want 3", out_ch(0)); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_dc_step();
        test_notch();
        test_dc_convergence();
        test_overrun();
        test_saturation();
        test_channel_independence();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
